mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_WORDS, default 256: data memory depth in 32-bit words, power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait cycles per load/store, range 0..15.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 ex_valid  in  1  EX stage holds a valid instruction.
REQ-006 saidaULA  in  32  ALU result from EX, used as byte address or pass-through result.
REQ-007 saidaSomador  in  32  branch target computed in EX.
REQ-008 zeroEx  in  1  ALU zero flag from EX.
REQ-009 dado2ALU_out  in  32  store data from EX.
REQ-010 RD  in  5  destination register from EX.
REQ-011 memRead, memWrite, branch, regWrite, memToReg  in  1 each  control bits from EX.
REQ-012 stall  out  1  freeze IF/ID/EX this cycle.
REQ-013 resultadoALU_MEM  out  32  registered ALU result, forwarded to EX forwarding muxes.
REQ-014 PCSrc  out  1  take branch; branch_target  out  32  registered saidaSomador.
REQ-015 wb_valid, wb_regWrite, wb_memToReg  out  1 each; wb_RD  out  5; wb_readData, wb_aluResult  out  32  MEM/WB register.
REQ-016 misalign_err  out  1  misaligned access flag (see Configuration).

Function
REQ-017 EX/MEM register SHALL capture all EX inputs on each rising edge when stall=0 and SHALL hold them when stall=1.
REQ-018 resultadoALU_MEM and branch_target SHALL be direct outputs of the EX/MEM register.
REQ-019 PCSrc SHALL equal exmem_valid AND exmem_branch AND exmem_zero, combinational from the EX/MEM register.
REQ-020 Word index SHALL be exmem_alu[log2(MEM_WORDS)+1:2]; upper address bits ignored (wrap modulo MEM_WORDS).
REQ-021 FSM states IDLE and BUSY with 4-bit wait counter; mem_op = exmem_valid AND (exmem_memRead OR exmem_memWrite).
REQ-022 IDLE with mem_op and WAIT_CYCLES>0: go BUSY, counter=1; with WAIT_CYCLES=0 the access completes this edge.
REQ-023 BUSY: counter increments each edge; access completes on the edge where counter==WAIT_CYCLES, FSM returns to IDLE.
REQ-024 stall SHALL be mem_op AND NOT completing-this-cycle; a load/store occupies MEM for exactly WAIT_CYCLES+1 cycles; non-memory ops take 1 cycle.
REQ-025 On completion: store writes exmem_data to memory; load latches memory word into wb_readData.
REQ-026 memRead and memWrite both set: treat as store only; wb_readData unchanged.
REQ-027 MEM/WB register SHALL load every edge; wb_valid=1 only when exmem_valid and not stall, else bubble (wb_valid=0, wb_regWrite=0).
REQ-028 wb_readData SHALL keep its previous value for non-load instructions.

Reset
REQ-029 reset_n low SHALL immediately clear the EX/MEM and MEM/WB registers, all outputs, counter, and force FSM to IDLE.
REQ-030 A store pending in BUSY when reset asserts SHALL NOT be committed; memory array contents are not cleared by reset.

Configuration
REQ-031 Macro MEM_ALIGN_CHECK_EN defined: access with exmem_alu[1:0]!=0 is suppressed (no write, no wait cycles, wb_regWrite=0) and misalign_err=1 for that cycle.
REQ-032 MEM_ALIGN_CHECK_EN undefined: address bits [1:0] ignored and misalign_err tied 0.

Verification
REQ-033 Store then load: WAIT_CYCLES=2, sw 0xDEADBEEF to addr 0x10, then lw addr 0x10 -> stall high 2 cycles each, wb_readData=0xDEADBEEF, wb_valid 1 cycle per op.
REQ-034 Branch: branch=1, zeroEx=1, saidaSomador=0x40 -> PCSrc=1 and branch_target=0x40 one cycle after capture; zeroEx=0 -> PCSrc=0.
REQ-035 Wrap: MEM_WORDS=256, sw 0x1234 to addr 0x400, lw addr 0x0 -> wb_readData=0x1234.
REQ-036 Reset mid-store: assert reset_n low while BUSY on sw 0xAA to 0x20 -> outputs 0 immediately; later lw 0x20 returns pre-existing value, not 0xAA.
REQ-037 Misaligned, MEM_ALIGN_CHECK_EN defined: sw to 0x13 -> misalign_err=1, stall=0, memory unchanged; undefined: writes word 0x10.
REQ-038 Back-to-back ALU ops (no mem): stall never asserts, resultadoALU_MEM follows saidaULA with 1-cycle latency.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, wait-state data memory, branch resolve, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned loads/stores and raises misalign_err.
module mem_stage #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [31:0] saidaULA,
  input  logic [31:0] saidaSomador,
  input  logic        zeroEx,
  input  logic [31:0] dado2ALU_out,
  input  logic [4:0]  RD,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        branch,
  input  logic        regWrite,
  input  logic        memToReg,
  output logic        stall,
  output logic [31:0] resultadoALU_MEM,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        wb_valid,
  output logic        wb_regWrite,
  output logic        wb_memToReg,
  output logic [4:0]  wb_RD,
  output logic [31:0] wb_readData,
  output logic [31:0] wb_aluResult,
  output logic        misalign_err
);

  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam logic [3:0]  WaitCnt = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  logic        valid_q, zero_q, memread_q, memwrite_q, branch_q, regwrite_q, memtoreg_q;
  logic [31:0] alu_q, target_q, data_q;
  logic [4:0]  rd_q;

  state_e      state_q;
  logic [3:0]  cnt_q;

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] read_data_q;

  logic          acc_req, misalign, mem_op, complete;
  logic [AW-1:0] idx;

  assign acc_req = valid_q & (memread_q | memwrite_q);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = acc_req & (alu_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_op   = acc_req & ~misalign;
  assign complete = mem_op & (((state_q == StIdle) & (WaitCnt == 4'd0)) |
                              ((state_q == StBusy) & (cnt_q == WaitCnt)));
  assign stall    = mem_op & ~complete;
  assign idx      = alu_q[AW+1:2];

  assign resultadoALU_MEM = alu_q;
  assign branch_target    = target_q;
  assign PCSrc            = valid_q & branch_q & zero_q;
  assign misalign_err     = misalign;
  assign wb_readData      = read_data_q;

  // EX/MEM register: frozen while the memory access is still waiting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      target_q   <= '0;
      zero_q     <= 1'b0;
      data_q     <= '0;
      rd_q       <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= ex_valid;
      alu_q      <= saidaULA;
      target_q   <= saidaSomador;
      zero_q     <= zeroEx;
      data_q     <= dado2ALU_out;
      rd_q       <= RD;
      memread_q  <= memRead;
      memwrite_q <= memWrite;
      branch_q   <= branch;
      regwrite_q <= regWrite;
      memtoreg_q <= memToReg;
    end
  end

  // Wait-state sequencer; counter value cnt_q is the number of BUSY edges seen so far.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_op && (WaitCnt != 4'd0)) begin
            state_q <= StBusy;
            cnt_q   <= 4'd1;
          end
        end
        StBusy: begin
          if (cnt_q == WaitCnt) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Memory array is deliberately not reset; a store only commits on its completing edge.
  always_ff @(posedge clock) begin
    if (complete && memwrite_q) begin
      mem_q[idx] <= data_q;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid     <= 1'b0;
      wb_regWrite  <= 1'b0;
      wb_memToReg  <= 1'b0;
      wb_RD        <= '0;
      wb_aluResult <= '0;
      read_data_q  <= '0;
    end else begin
      wb_valid     <= valid_q & ~stall;
      wb_regWrite  <= valid_q & ~stall & regwrite_q & ~misalign;
      wb_memToReg  <= valid_q & ~stall & memtoreg_q;
      wb_RD        <= rd_q;
      wb_aluResult <= alu_q;
      if (complete && memread_q && !memwrite_q) begin
        read_data_q <= mem_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops vs. a reference model.
module tb_mem_stage;

  localparam int unsigned MemWords = 256;
  localparam int unsigned WaitCyc  = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] saidaULA = '0, saidaSomador = '0, dado2ALU_out = '0;
  logic        zeroEx = 1'b0;
  logic [4:0]  RD = '0;
  logic        memRead = 1'b0, memWrite = 1'b0, branch = 1'b0, regWrite = 1'b0, memToReg = 1'b0;
  logic        stall, PCSrc, wb_valid, wb_regWrite, wb_memToReg, misalign_err;
  logic [31:0] resultadoALU_MEM, branch_target, wb_readData, wb_aluResult;
  logic [4:0]  wb_RD;

  mem_stage #(.MEM_WORDS(MemWords), .WAIT_CYCLES(WaitCyc)) dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .saidaULA(saidaULA),
    .saidaSomador(saidaSomador), .zeroEx(zeroEx), .dado2ALU_out(dado2ALU_out), .RD(RD),
    .memRead(memRead), .memWrite(memWrite), .branch(branch), .regWrite(regWrite),
    .memToReg(memToReg), .stall(stall), .resultadoALU_MEM(resultadoALU_MEM), .PCSrc(PCSrc),
    .branch_target(branch_target), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_memToReg(wb_memToReg), .wb_RD(wb_RD), .wb_readData(wb_readData),
    .wb_aluResult(wb_aluResult), .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: word-addressed memory and the last loaded word.
  logic [31:0] ref_mem [MemWords];
  int          known_q [$];
  logic [31:0] ref_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction into an otherwise idle pipe and follow it through to WB.
  task automatic do_op(input bit rd, input bit wr, input bit br, input bit zf, input bit rw,
                       input bit m2r, input logic [31:0] alu, input logic [31:0] data,
                       input logic [31:0] tgt, input logic [4:0] rdst);
    bit   is_mem, mis;
    int   exp_wait, n, widx;
    is_mem   = rd | wr;
    mis      = AlignChk && is_mem && ((alu % 4) != 0);
    exp_wait = (is_mem && !mis) ? WaitCyc : 0;
    widx     = int'((alu / 4) % MemWords);
    ex_valid = 1'b1; saidaULA = alu; saidaSomador = tgt; zeroEx = zf; dado2ALU_out = data;
    RD = rdst; memRead = rd; memWrite = wr; branch = br; regWrite = rw; memToReg = m2r;
    tick();
    ex_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; branch = 1'b0;
    chk("alu_fwd", resultadoALU_MEM, alu);
    chk("br_target", branch_target, tgt);
    chk("pcsrc", {31'b0, PCSrc}, {31'b0, br & zf});
    chk("misalign", {31'b0, misalign_err}, {31'b0, mis});
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("stall_cycles", n, exp_wait);
    if (is_mem && !mis) begin
      if (wr) begin
        ref_mem[widx] = data;
        known_q.push_back(widx);
      end else begin
        ref_rd = ref_mem[widx];
      end
    end
    tick();
    chk("wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("wb_rd", {27'b0, wb_RD}, {27'b0, rdst});
    chk("wb_alu", wb_aluResult, alu);
    chk("wb_regwrite", {31'b0, wb_regWrite}, {31'b0, rw & ~mis});
    chk("wb_readdata", wb_readData, ref_rd);
    tick();
    chk("wb_bubble", {30'b0, wb_valid, wb_regWrite}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev, cur;
    int          kind, w, up;

    // Reset state
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_alu", resultadoALU_MEM, 32'd0);
    chk("rst_wb", {29'b0, wb_valid, wb_regWrite, PCSrc}, 32'd0);
    chk("rst_readdata", wb_readData, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Store then load
    do_op(0, 1, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd0);
    do_op(1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd3);
    chk("lw_deadbeef", wb_readData, 32'hDEADBEEF);

    // Branch taken / not taken
    do_op(0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 32'h40, 5'd0);
    do_op(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h40, 5'd0);

    // Address wrap
    do_op(0, 1, 0, 0, 0, 0, 32'h400, 32'h1234, 32'h0, 5'd0);
    do_op(1, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 5'd4);
    chk("wrap_load", wb_readData, 32'h1234);

    // Reset in the middle of a store
    do_op(0, 1, 0, 0, 0, 0, 32'h20, 32'h55, 32'h0, 5'd0);
    ex_valid = 1'b1; saidaULA = 32'h20; dado2ALU_out = 32'hAA; memWrite = 1'b1; RD = 5'd0;
    tick();
    ex_valid = 1'b0; memWrite = 1'b0;
    tick();
    chk("busy_stall", {31'b0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_alu", resultadoALU_MEM, 32'd0);
    chk("rst_mid_stall", {30'b0, stall, wb_valid}, 32'd0);
    chk("rst_mid_rdata", wb_readData, 32'd0);
    ref_rd = '0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    do_op(1, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0, 5'd5);
    chk("no_commit", wb_readData, 32'h55);

    // Misaligned store, then read back the aligned word
    do_op(0, 1, 0, 0, 0, 0, 32'h13, 32'h77777777, 32'h0, 5'd0);
    do_op(1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd6);

    // Back-to-back ALU ops
    prev = resultadoALU_MEM;
    for (int i = 0; i < 10; i++) begin
      cur = $urandom;
      ex_valid = 1'b1; saidaULA = cur; regWrite = 1'b1;
      tick();
      chk("b2b_alu", resultadoALU_MEM, cur);
      chk("b2b_stall", {31'b0, stall}, 32'd0);
      if (i > 0) chk("b2b_wb", wb_aluResult, prev);
      prev = cur;
    end
    ex_valid = 1'b0; regWrite = 1'b0;
    tick();
    tick();

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      up   = $urandom_range(0, 3);
      w    = $urandom_range(0, 31);
      if (kind == 3 && known_q.size() > 0) w = known_q[$urandom_range(0, known_q.size() - 1)];
      else if (kind == 3) kind = 2;
      cur = 32'((up * MemWords + w) * 4);
      unique case (kind)
        0: do_op(0, 0, 0, 1'($urandom), 1, 0, $urandom, 32'h0, $urandom, 5'($urandom));
        1: do_op(0, 0, 1, 1'($urandom), 0, 0, $urandom, 32'h0, $urandom, 5'($urandom));
        2: do_op(0, 1, 0, 0, 0, 0, cur, $urandom, 32'h0, 5'($urandom));
        3: do_op(1, 0, 0, 0, 1, 1, cur, 32'h0, 32'h0, 5'($urandom));
        default: do_op(1, 1, 0, 0, 0, 0, cur, $urandom, 32'h0, 5'($urandom));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
